// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_loader                                                  |
// | Description : Boot-time program loader. Receives a length-prefixed,        |
// |               XOR-checksummed byte stream over valid/ready, packs it into  |
// |               32-bit big-endian words, writes them to instruction memory   |
// |               and releases the processor reset only after a verified load. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high reset
//   start        : one-cycle load request (ignored while busy)
//   in_data      : stream byte
//   in_valid     : in_data valid this cycle
//   in_ready     : loader accepts a byte this cycle
//   imem_we      : one-cycle write strobe per assembled word
//   imem_waddr   : word address of the write
//   imem_wdata   : word being written
//   cpu_reset    : processor reset, high until a verified image is in place
//   busy         : load in progress
//   done         : last load completed with a good checksum
//   error        : last load failed (length overflow or bad checksum)
//   words_loaded : words written in the current or last load
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int          CNT_W   = ADDR_W + 1;
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t              state_q,     state_d;
  logic [7:0]          len_hi_q,    len_hi_d;
  logic [15:0]         len_q,       len_d;
  logic [1:0]          byte_cnt_q,  byte_cnt_d;
  logic [CNT_W-1:0]    word_cnt_q,  word_cnt_d;
  logic [7:0]          chk_q,       chk_d;
  logic [23:0]         shift_q,     shift_d;
  logic                we_q,        we_d;
  logic [ADDR_W-1:0]   waddr_q,     waddr_d;
  logic [31:0]         wdata_q,     wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                error_q,     error_d;

  logic        accept;
  logic        all_written;
  logic [15:0] len_rx;

  // Once the last word has been issued the loader lingers one cycle in DATA
  // (the cycle its write strobe is high) with in_ready low, so the checksum
  // byte is only ever taken in CHK and the strobe never leaks past DATA.
  assign all_written = (16'(word_cnt_q) == len_q);
  assign len_rx      = {len_hi_q, in_data};

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_CHK: in_ready = 1'b1;
      S_DATA:                    in_ready = !all_written;
      default:                   in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    chk_d       = chk_q;
    shift_d     = shift_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_LEN_HI;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          cpu_reset_d = 1'b1;
          len_hi_d    = 8'd0;
          len_d       = 16'd0;
          byte_cnt_d  = 2'd0;
          word_cnt_d  = '0;
          chk_d       = 8'd0;
          shift_d     = 24'd0;
        end else if (state_q == S_DONE) begin
          // Registered release: low on the cycle after DONE is entered.
          cpu_reset_d = 1'b0;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          chk_d    = chk_q ^ in_data;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          chk_d = chk_q ^ in_data;
          len_d = len_rx;
          if ({1'b0, len_rx} > MAX_LEN) begin
            // Rejected before any write can happen.
            state_d = S_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (len_rx == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (all_written) begin
          state_d = S_CHK;
        end else if (accept) begin
          chk_d = chk_q ^ in_data;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            waddr_d    = word_cnt_q[ADDR_W-1:0];
            wdata_d    = {shift_q, in_data};
            word_cnt_d = word_cnt_q + CNT_W'(1);
            byte_cnt_d = 2'd0;
          end else begin
            shift_d    = {shift_q[15:0], in_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_CHK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (in_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_hi_q    <= 8'd0;
      len_q       <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= '0;
      chk_q       <= 8'd0;
      shift_q     <= 24'd0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= 32'd0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      chk_q       <= chk_d;
      shift_q     <= shift_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_loader                                               |
// | Description : Directed self-checking bench for imem_loader.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int BUDGET = 50;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int passed = 0;
  int total  = 0;

  logic [39:0] wq[$];
  logic [7:0]  stim[$];

  imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wq.push_back({imem_waddr, imem_wdata});
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte; returns one step after the accepting edge. With gap set,
  // in_valid is dropped for one cycle afterwards, optionally pulsing start.
  task automatic send(input logic [7:0] b, input bit gap, input bit poke);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < BUDGET) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      check("ready_timeout", 40'(in_ready), 40'd1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      if (gap) begin
        start = poke;
        tick();
        start = 1'b0;
      end
    end
  endtask

  task automatic send_all(input int n, input bit gap, input int poke_at);
    for (int i = 0; i < n; i++) send(stim[i], gap, (i == poke_at));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    check("rst_cpu_reset", 40'(cpu_reset), 40'd1);
    check("rst_busy",      40'(busy),      40'd0);
    check("rst_done",      40'(done),      40'd0);
    check("rst_error",     40'(error),     40'd0);
    check("rst_words",     40'(words_loaded), 40'd0);
    check("rst_we",        40'(imem_we),   40'd0);
    check("rst_ready",     40'(in_ready),  40'd0);
    reset = 1'b0;
    tick();

    // Good two-word load.
    wq.delete();
    pulse_start();
    check("g_busy",  40'(busy),      40'd1);
    check("g_cpu",   40'(cpu_reset), 40'd1);
    check("g_ready", 40'(in_ready),  40'd1);
    stim = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h3A};
    send_all(11, 1'b0, -1);
    check("g_done",     40'(done),      40'd1);
    check("g_error",    40'(error),     40'd0);
    check("g_busy_end", 40'(busy),      40'd0);
    check("g_cpu_hold", 40'(cpu_reset), 40'd1);
    tick();
    check("g_cpu_rel",  40'(cpu_reset), 40'd0);
    check("g_words",    40'(words_loaded), 40'd2);
    check("g_nwr",      40'(wq.size()), 40'd2);
    check("g_wr0",      wq[0], {8'h00, 32'h3C010005});
    check("g_wr1",      wq[1], {8'h01, 32'h00000000});

    // Empty image, restarted from DONE.
    wq.delete();
    pulse_start();
    check("e_cpu_back", 40'(cpu_reset), 40'd1);
    check("e_done_clr", 40'(done),      40'd0);
    check("e_words_clr", 40'(words_loaded), 40'd0);
    stim = '{8'h00, 8'h00, 8'h00};
    send_all(3, 1'b0, -1);
    check("e_done", 40'(done), 40'd1);
    tick();
    check("e_cpu_rel", 40'(cpu_reset), 40'd0);
    check("e_nwr",     40'(wq.size()), 40'd0);
    check("e_words",   40'(words_loaded), 40'd0);

    // Bad checksum, then a good reload.
    wq.delete();
    pulse_start();
    stim = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h3B};
    send_all(11, 1'b0, -1);
    check("b_error", 40'(error), 40'd1);
    check("b_done",  40'(done),  40'd0);
    check("b_busy",  40'(busy),  40'd0);
    tick();
    check("b_cpu",   40'(cpu_reset), 40'd1);
    check("b_words", 40'(words_loaded), 40'd2);
    check("b_nwr",   40'(wq.size()), 40'd2);
    check("b_wr0",   wq[0], {8'h00, 32'h3C010005});
    check("b_wr1",   wq[1], {8'h01, 32'h00000000});
    pulse_start();
    check("b_err_clr", 40'(error), 40'd0);
    stim[10] = 8'h3A;
    send_all(11, 1'b0, -1);
    check("b_reload_done",  40'(done),  40'd1);
    check("b_reload_error", 40'(error), 40'd0);

    // Length overflow: N = 257.
    wq.delete();
    pulse_start();
    stim = '{8'h01, 8'h01};
    send_all(2, 1'b0, -1);
    check("o_error", 40'(error),    40'd1);
    check("o_busy",  40'(busy),     40'd0);
    check("o_ready", 40'(in_ready), 40'd0);
    check("o_done",  40'(done),     40'd0);
    repeat (3) tick();
    check("o_cpu",   40'(cpu_reset), 40'd1);
    check("o_nwr",   40'(wq.size()), 40'd0);
    check("o_words", 40'(words_loaded), 40'd0);

    // Backpressure with in_valid toggling and a stray start mid-load.
    wq.delete();
    pulse_start();
    stim = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h3A};
    send_all(11, 1'b1, 5);
    check("p_done",  40'(done),  40'd1);
    check("p_error", 40'(error), 40'd0);
    check("p_words", 40'(words_loaded), 40'd2);
    check("p_nwr",   40'(wq.size()), 40'd2);
    check("p_wr0",   wq[0], {8'h00, 32'h3C010005});
    check("p_wr1",   wq[1], {8'h01, 32'h00000000});
    check("p_cpu_rel", 40'(cpu_reset), 40'd0);

    // Reset after six data bytes.
    wq.delete();
    pulse_start();
    send_all(8, 1'b0, -1);
    check("r_words_mid", 40'(words_loaded), 40'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_cpu",   40'(cpu_reset), 40'd1);
    check("r_busy",  40'(busy),      40'd0);
    check("r_words", 40'(words_loaded), 40'd0);
    check("r_ready", 40'(in_ready),  40'd0);
    check("r_done",  40'(done),      40'd0);
    repeat (4) tick();
    check("r_nwr",   40'(wq.size()), 40'd1);
    check("r_wr0",   wq[0], {8'h00, 32'h3C010005});
    check("r_idle_ready", 40'(in_ready), 40'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction memory and the program counter.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit instruction words.
- Writes each word into instruction memory and holds the processor in reset until a complete, checksum-verified image has been written.
- After a successful load it releases cpu_reset, which drives the PC reset input.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- MAX_WORDS, 256, largest accepted image in words. Must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- in_data  input  8  incoming stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_waddr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  instruction word to write.
- cpu_reset  output  1  reset to the PC/processor; high while not loaded.
- busy  output  1  a load is in progress.
- done  output  1  the last load completed with a good checksum.
- error  output  1  the last load failed.
- words_loaded  output  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset values:
  - cpu_reset=1; all other outputs are 0.
  - State is IDLE; internal byte counter, word counter, checksum accumulator and shift register are all 0.
- Handshake:
  - A byte is accepted when in_valid && in_ready at a rising edge.
  - in_ready=1 only in states LEN_HI, LEN_LO, DATA and CHK.
  - in_valid may gap at any time; there is no timeout.
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N×4 data bytes, most significant byte first, then one checksum byte.
- Checksum: XOR of every byte from LEN_HI through the last data byte. The received checksum byte must equal it.
- FSM:
  - IDLE: on start go to LEN_HI. Set busy=1, clear done, error and words_loaded. cpu_reset stays 1.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO on accept:
    - If N > MAX_WORDS, go to ERR.
    - If N == 0, go to CHK.
    - Otherwise go to DATA.
  - DATA: shift each accepted byte into the word register. On the 4th byte of a word, the next cycle has imem_we=1, with imem_waddr = current word index and imem_wdata = the assembled word. The word index increments and words_loaded increments. After word N-1 is written, go to CHK.
  - DATA accepts bytes in the cycle imem_we is high; the write is a registered side output and causes no stall.
  - CHK on accept:
    - Match: go to DONE (done=1, busy=0). cpu_reset falls to 0 on the cycle after entering DONE.
    - Mismatch: go to ERR (error=1, busy=0, cpu_reset stays 1).
  - DONE / ERR: hold. A start pulse re-enters LEN_HI exactly as from IDLE, and cpu_reset returns to 1 on that same edge.
- start while busy=1 is ignored.
- imem_we is high for exactly one cycle per word; it is never asserted outside DATA, nor on the cycle that follows entry to DATA.
- Word addresses run 0..N-1 with no wrap-around. Length overflow is rejected before any write occurs.
- reset mid-load: everything returns to reset values on the next edge. Words already written stay in memory (no rollback). cpu_reset=1.
- reset has priority over start when both are high.
- words_loaded holds its value in DONE and ERR.

Test Plan:
- Good load, start then stream 00 02 3C 01 00 05 00 00 00 00 3A → exactly two writes: (addr 0, 0x3C010005) and (addr 1, 0x00000000). Then done=1, error=0, words_loaded=2, and cpu_reset=0 one cycle after DONE.
- Empty image, stream 00 00 00 → no imem_we, done=1, cpu_reset falls to 0.
- Bad checksum, same as the first scenario but final byte 3B → both writes still occur, then error=1, done=0, cpu_reset stays 1. A subsequent start plus the correct stream gives done=1.
- Overflow, stream 01 01 (N=257 > 256) → error=1 right after LEN_LO is accepted, no imem_we ever asserted, in_ready=0.
- Backpressure, the first scenario with in_valid toggling 1/0 every cycle and start pulsed mid-load → identical writes and result, and the start pulse has no effect.
- Reset mid-load, assert reset after 6 data bytes → the next cycle has cpu_reset=1, busy=0, words_loaded=0, state IDLE. The word at addr 0 has already been written, and no further writes occur.
